// File: rtl/taglist_player.sv
// ============================================================================
// Module  : taglist_player
// Purpose : Reads one taglist entry, validates it, then steps the tag ROM
//           address from first to last. Optional macro: TAGLIST_LOOP_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module taglist_player #(
  parameter int AW       = 10,
  parameter int SW       = 7,
  parameter int STEP_DIV = 1
) (
  input  logic          clk_1KHz,
  input  logic          reset_n,
  input  logic          start,
  input  logic [SW-1:0] seq_sel,
  input  logic          stop,
`ifdef TAGLIST_LOOP_EN
  input  logic          loop,
`endif
  output logic [SW-1:0] ram_addr,
  output logic          ram_rd,
  input  logic [31:0]   ram_data,
  output logic [AW-1:0] rom_addr,
  output logic          rom_valid,
  output logic          seq_last,
  output logic          rom_end,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int             FIRST_LSB = AW + 1;
  localparam int             SEQ_LSB   = 2 * AW + 1;
  localparam int             RSV_LSB   = 2 * AW + SW + 1;
  localparam int             CW        = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0]  STEP_LAST = CW'(STEP_DIV - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    CHECK = 3'd2,
    PLAY  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] seq_q, seq_d;
  logic          ram_rd_q, ram_rd_d;
  logic [AW-1:0] cur_q, cur_d;
  logic [AW-1:0] last_q, last_d;
  logic          rom_end_q, rom_end_d;
  logic [CW-1:0] step_q, step_d;
  logic          err_q, err_d;
`ifdef TAGLIST_LOOP_EN
  logic [AW-1:0] first_q, first_d;
`endif

  logic [AW-1:0] w_first;
  logic [AW-1:0] w_last;
  logic          w_bad_entry;
  logic          w_step_end;
  logic          w_at_last;

  assign w_first     = ram_data[FIRST_LSB +: AW];
  assign w_last      = ram_data[1 +: AW];
  assign w_bad_entry = ((ram_data >> RSV_LSB) != 32'd0) ||
                       (ram_data[SEQ_LSB +: SW] != seq_q) ||
                       (w_first > w_last);
  assign w_step_end  = (step_q == STEP_LAST);
  assign w_at_last   = (cur_q == last_q);

  always_comb begin
    state_d   = state_q;
    seq_d     = seq_q;
    ram_rd_d  = 1'b0;
    cur_d     = cur_q;
    last_d    = last_q;
    rom_end_d = rom_end_q;
    step_d    = step_q;
    err_d     = err_q;
`ifdef TAGLIST_LOOP_EN
    first_d   = first_q;
`endif
    case (state_q)
      IDLE: begin
        // start wins over a simultaneous stop here; stop only aborts work in flight
        if (start) begin
          seq_d    = seq_sel;
          ram_rd_d = 1'b1;
          err_d    = 1'b0;
          state_d  = FETCH;
        end
      end
      FETCH: begin
        state_d = stop ? DONE : CHECK;
      end
      CHECK: begin
        if (stop) begin
          state_d = DONE;
        end else if (w_bad_entry) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cur_d     = w_first;
          last_d    = w_last;
          rom_end_d = ram_data[0];
          step_d    = '0;
`ifdef TAGLIST_LOOP_EN
          first_d   = w_first;
`endif
          state_d   = PLAY;
        end
      end
      PLAY: begin
        if (stop) begin
          state_d = DONE;
        end else if (w_step_end) begin
          step_d = '0;
          if (w_at_last) begin
`ifdef TAGLIST_LOOP_EN
            if (loop) begin
              cur_d = first_q;
            end else begin
              state_d = DONE;
            end
`else
            state_d = DONE;
`endif
          end else begin
            cur_d = cur_q + AW'(1);
          end
        end else begin
          step_d = step_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_1KHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      seq_q     <= '0;
      ram_rd_q  <= 1'b0;
      cur_q     <= '0;
      last_q    <= '0;
      rom_end_q <= 1'b0;
      step_q    <= '0;
      err_q     <= 1'b0;
`ifdef TAGLIST_LOOP_EN
      first_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      seq_q     <= seq_d;
      ram_rd_q  <= ram_rd_d;
      cur_q     <= cur_d;
      last_q    <= last_d;
      rom_end_q <= rom_end_d;
      step_q    <= step_d;
      err_q     <= err_d;
`ifdef TAGLIST_LOOP_EN
      first_q   <= first_d;
`endif
    end
  end

  // Outputs decode straight from flops so an async reset clears them at once
  assign ram_addr  = seq_q;
  assign ram_rd    = ram_rd_q;
  assign rom_addr  = cur_q;
  assign rom_valid = (state_q == PLAY) && (step_q == '0);
  assign seq_last  = (state_q == PLAY) && w_at_last;
  assign rom_end   = (state_q == PLAY) && rom_end_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign err       = err_q;

endmodule

`default_nettype wire
